// File: rtl/adder_share_pkg.sv
// Shared types for the time-shared adder: FSM state encoding and the
// round-robin pick helper used by the requester arbiter.
package adder_share_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } adder_share_state_e;

    localparam int RR_MAX_REQ = 16;
    localparam int RR_IDX_W   = 4;

    typedef struct packed {
        logic                found;
        logic [RR_IDX_W-1:0] idx;
    } rr_pick_t;

    // Valid bits above the real requester count are tied low, so wrapping
    // modulo 16 yields the same winner as wrapping modulo REQ_NUM.
    function automatic rr_pick_t rr_pick(input logic [RR_MAX_REQ-1:0] valid,
                                         input logic [RR_IDX_W-1:0]   ptr);
        rr_pick_t            pick;
        logic [RR_IDX_W-1:0] k;
        pick = '0;
        for (int i = RR_MAX_REQ - 1; i >= 0; i--) begin
            k = ptr + RR_IDX_W'(i);
            if (valid[k]) begin
                pick.found = 1'b1;
                pick.idx   = k;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/adder_nnbit_ahead_serial.sv
// DATA_WIDTH adder built from 4-bit carry-lookahead groups whose group
// carries ripple serially from the least-significant group upward.
module adder_nnbit_ahead_serial #(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] num_a,
    input  logic [DATA_WIDTH-1:0] num_b,
    input  logic                  cry_in,
    output logic [DATA_WIDTH-1:0] res,
    output logic                  cry_out
);

    localparam int GRP_NUM = DATA_WIDTH / 4;

    if ((DATA_WIDTH % 4) != 0 || DATA_WIDTH < 4) begin : g_width_check
        $error("adder_nnbit_ahead_serial: DATA_WIDTH must be a multiple of 4 and >= 4");
    end

    for (genvar gi = 0; gi < GRP_NUM; gi++) begin : g_grp
        logic [3:0] g;
        logic [3:0] p;
        logic       cin_g;
        logic       c1, c2, c3;
        logic       cout_g;

        if (gi == 0) begin : g_first
            assign cin_g = cry_in;
        end else begin : g_chain
            assign cin_g = g_grp[gi-1].cout_g;
        end

        assign g = num_a[gi*4 +: 4] & num_b[gi*4 +: 4];
        assign p = num_a[gi*4 +: 4] ^ num_b[gi*4 +: 4];

        // Every group carry is a flat sum of products of g/p and the group carry-in.
        assign c1     = g[0] | (p[0] & cin_g);
        assign c2     = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin_g);
        assign c3     = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                      | (p[2] & p[1] & p[0] & cin_g);
        assign cout_g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                      | (p[3] & p[2] & p[1] & g[0])
                      | (p[3] & p[2] & p[1] & p[0] & cin_g);

        assign res[gi*4 +: 4] = p ^ {c3, c2, c1, cin_g};
    end

    assign cry_out = g_grp[GRP_NUM-1].cout_g;

endmodule

// File: rtl/adder_rr_arbiter.sv
// Round-robin requester pick with a registered search pointer; the pointer
// advances past the served requester when the owner's response completes.
module adder_rr_arbiter
    import adder_share_pkg::*;
#(
    parameter int REQ_NUM = 4
) (
    input  logic                       clk,
    input  logic                       srst,
    input  logic [REQ_NUM-1:0]         req_valid,
    output logic                       grant_found,
    output logic [$clog2(REQ_NUM)-1:0] grant_id,
    input  logic                       advance,
    input  logic [$clog2(REQ_NUM)-1:0] advance_id
);

    localparam int ID_W = $clog2(REQ_NUM);

    if (REQ_NUM < 2 || REQ_NUM > RR_MAX_REQ) begin : g_req_check
        $error("adder_rr_arbiter: REQ_NUM must be in 2..16");
    end

    logic [ID_W-1:0] ptr_reg;
    rr_pick_t        pick;

    always_ff @(posedge clk) begin
        if (srst) begin
            ptr_reg <= '0;
        end else if (advance) begin
            ptr_reg <= (advance_id == ID_W'(REQ_NUM - 1)) ? '0 : advance_id + ID_W'(1);
        end
    end

    always_comb begin
        pick        = rr_pick(RR_MAX_REQ'(req_valid), RR_IDX_W'(ptr_reg));
        grant_found = pick.found;
        grant_id    = ID_W'(pick.idx);
    end

endmodule

// File: rtl/adder_nnbit_share_arbiter.sv
// Time-shares one serial-lookahead adder among REQ_NUM valid/ready clients:
// grant in IDLE, add from registered operands in CALC, hold the result in RESP.
module adder_nnbit_share_arbiter
    import adder_share_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int REQ_NUM    = 4
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [REQ_NUM-1:0]            i_req_valid,
    output logic [REQ_NUM-1:0]            o_req_ready,
    input  logic [REQ_NUM*DATA_WIDTH-1:0] i_req_num_a,
    input  logic [REQ_NUM*DATA_WIDTH-1:0] i_req_num_b,
    input  logic [REQ_NUM-1:0]            i_req_cry,
    output logic [REQ_NUM-1:0]            o_rsp_valid,
    input  logic [REQ_NUM-1:0]            i_rsp_ready,
    output logic [DATA_WIDTH-1:0]         o_rsp_res,
    output logic                          o_rsp_cry,
    output logic [$clog2(REQ_NUM)-1:0]    o_rsp_id,
    output logic                          o_busy
);

    localparam int ID_W = $clog2(REQ_NUM);

    if ((DATA_WIDTH % 4) != 0 || DATA_WIDTH < 4) begin : g_width_check
        $error("adder_nnbit_share_arbiter: DATA_WIDTH must be a multiple of 4 and >= 4");
    end

    adder_share_state_e    state_reg, state_next;
    logic [DATA_WIDTH-1:0] a_reg, b_reg, res_reg;
    logic                  cin_reg, cry_reg;
    logic [ID_W-1:0]       id_reg;

    logic                  grant_found;
    logic [ID_W-1:0]       grant_id;
    logic                  req_fire, rsp_fire;
    logic [DATA_WIDTH-1:0] sum;
    logic                  sum_cry;

    adder_rr_arbiter #(
        .REQ_NUM(REQ_NUM)
    ) u_arb (
        .clk        (i_clk),
        .srst       (i_rst),
        .req_valid  (i_req_valid),
        .grant_found(grant_found),
        .grant_id   (grant_id),
        .advance    (rsp_fire),
        .advance_id (id_reg)
    );

    // Fed only from registers, so the carry chain never sees requester logic.
    adder_nnbit_ahead_serial #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_adder (
        .num_a  (a_reg),
        .num_b  (b_reg),
        .cry_in (cin_reg),
        .res    (sum),
        .cry_out(sum_cry)
    );

    always_comb begin
        state_next  = state_reg;
        req_fire    = 1'b0;
        rsp_fire    = 1'b0;
        o_req_ready = '0;
        case (state_reg)
            IDLE: begin
                if (grant_found) begin
                    o_req_ready[grant_id] = 1'b1;
                    req_fire              = 1'b1;
                    state_next            = CALC;
                end
            end
            CALC: state_next = RESP;
            RESP: begin
                if (i_rsp_ready[id_reg]) begin
                    rsp_fire   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            cin_reg   <= 1'b0;
            id_reg    <= '0;
            res_reg   <= '0;
            cry_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (req_fire) begin
                a_reg   <= i_req_num_a[grant_id*DATA_WIDTH +: DATA_WIDTH];
                b_reg   <= i_req_num_b[grant_id*DATA_WIDTH +: DATA_WIDTH];
                cin_reg <= i_req_cry[grant_id];
                id_reg  <= grant_id;
            end
            if (state_reg == CALC) begin
                res_reg <= sum;
                cry_reg <= sum_cry;
            end
        end
    end

    always_comb begin
        o_rsp_valid = '0;
        if (state_reg == RESP) begin
            o_rsp_valid[id_reg] = 1'b1;
        end
    end

    assign o_rsp_res = res_reg;
    assign o_rsp_cry = cry_reg;
    assign o_rsp_id  = id_reg;
    assign o_busy    = (state_reg != IDLE);

endmodule

// File: tb/tb_adder_nnbit_share_arbiter.sv
// Bench for the shared-adder arbiter: directed scenarios plus random traffic,
// checked by a transaction-level model and an expected-response queue.
module tb_adder_nnbit_share_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int IW = 2;

    logic              i_clk = 1'b0;
    logic              i_rst;
    logic [N-1:0]      i_req_valid;
    logic [N-1:0]      o_req_ready;
    logic [N*DW-1:0]   i_req_num_a;
    logic [N*DW-1:0]   i_req_num_b;
    logic [N-1:0]      i_req_cry;
    logic [N-1:0]      o_rsp_valid;
    logic [N-1:0]      i_rsp_ready;
    logic [DW-1:0]     o_rsp_res;
    logic              o_rsp_cry;
    logic [IW-1:0]     o_rsp_id;
    logic              o_busy;

    adder_nnbit_share_arbiter #(
        .DATA_WIDTH(DW),
        .REQ_NUM   (N)
    ) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_req_valid(i_req_valid),
        .o_req_ready(o_req_ready),
        .i_req_num_a(i_req_num_a),
        .i_req_num_b(i_req_num_b),
        .i_req_cry  (i_req_cry),
        .o_rsp_valid(o_rsp_valid),
        .i_rsp_ready(i_rsp_ready),
        .o_rsp_res  (o_rsp_res),
        .o_rsp_cry  (o_rsp_cry),
        .o_rsp_id   (o_rsp_id),
        .o_busy     (o_busy)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        int            id;
        logic [DW-1:0] res;
        logic          cry;
    } exp_t;

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc      = 0;
    bit   mon_en   = 1'b0;
    bit   hold_mode = 1'b0;

    // Transaction-level model: idle flag, search pointer, owner, cycles since grant.
    bit   m_idle  = 1'b1;
    bit   m_fresh = 1'b1;
    int   m_ptr   = 0;
    int   m_id    = 0;
    int   m_age   = 0;
    exp_t exp_q[$];

    int            grants[N];
    bit            acc_seen[N];
    int            grant_log[$];
    int            grant_cyc[$];
    int            n_rsp = 0;
    logic [DW-1:0] last_res;
    logic          last_cry;
    int            last_id;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compare outputs against the model, then advance the model by
    // the handshakes that the coming rising edge will perform.
    always @(negedge i_clk) begin
        int            win;
        int            k;
        logic [N-1:0]  exp_ready;
        logic [N-1:0]  exp_rv;
        logic [DW:0]   s;
        exp_t          e;
        if (mon_en) begin
            win       = -1;
            exp_ready = '0;
            if (m_idle) begin
                for (int i = 0; i < N; i++) begin
                    k = (m_ptr + i) % N;
                    if (win < 0 && i_req_valid[k]) win = k;
                end
            end
            if (win >= 0) exp_ready[win] = 1'b1;
            exp_rv = '0;
            if (!m_idle && m_age >= 2) exp_rv[m_id] = 1'b1;

            check("req_ready", 64'(o_req_ready), 64'(exp_ready));
            check("rsp_valid", 64'(o_rsp_valid), 64'(exp_rv));
            check("busy", 64'(o_busy), 64'(!m_idle));
            if (exp_rv != '0 && exp_q.size() > 0) begin
                check("rsp_res", 64'(o_rsp_res), 64'(exp_q[0].res));
                check("rsp_cry", 64'(o_rsp_cry), 64'(exp_q[0].cry));
                check("rsp_id", 64'(o_rsp_id), 64'(exp_q[0].id));
            end
            if (m_fresh) begin
                check("reset_res", 64'(o_rsp_res), 64'(0));
                check("reset_cry", 64'(o_rsp_cry), 64'(0));
                check("reset_id", 64'(o_rsp_id), 64'(0));
            end

            if (i_rst) begin
                m_idle  = 1'b1;
                m_fresh = 1'b1;
                m_ptr   = 0;
                exp_q.delete();
            end else if (m_idle) begin
                if (win >= 0) begin
                    s = {1'b0, i_req_num_a[win*DW +: DW]} + {1'b0, i_req_num_b[win*DW +: DW]}
                      + (DW+1)'(i_req_cry[win]);
                    e.id  = win;
                    e.res = s[DW-1:0];
                    e.cry = s[DW];
                    exp_q.push_back(e);
                    grants[win]++;
                    acc_seen[win] = 1'b1;
                    grant_log.push_back(win);
                    grant_cyc.push_back(cyc);
                    m_idle  = 1'b0;
                    m_fresh = 1'b0;
                    m_age   = 1;
                    m_id    = win;
                end
            end else if (m_age >= 2) begin
                if (i_rsp_ready[m_id]) begin
                    if (exp_q.size() > 0) e = exp_q.pop_front();
                    last_res = o_rsp_res;
                    last_cry = o_rsp_cry;
                    last_id  = int'(o_rsp_id);
                    n_rsp++;
                    $display("rsp cycle=%0d id=%0d res=%02h cry=%0b", cyc, last_id, last_res, last_cry);
                    m_ptr  = (m_id + 1) % N;
                    m_idle = 1'b1;
                end
            end else begin
                m_age++;
            end
            cyc++;
        end
    end

    task automatic cycle();
        @(posedge i_clk);
        #1;
        for (int k = 0; k < N; k++) begin
            if (acc_seen[k]) begin
                acc_seen[k] = 1'b0;
                if (!hold_mode) i_req_valid[k] = 1'b0;
            end
        end
    endtask

    task automatic set_req(input int k, input logic [DW-1:0] a, input logic [DW-1:0] b, input logic c);
        i_req_num_a[k*DW +: DW] = a;
        i_req_num_b[k*DW +: DW] = b;
        i_req_cry[k]            = c;
        i_req_valid[k]          = 1'b1;
    endtask

    task automatic wait_grant(input int k);
        int start = grants[k];
        int t = 0;
        while (grants[k] == start && t < 60) begin
            cycle();
            t++;
        end
        if (grants[k] == start) begin
            n_checks++;
            n_errors++;
            $display("FAIL wait_grant: requester %0d not granted within 60 cycles", k);
        end
    endtask

    task automatic wait_rsp();
        int start = n_rsp;
        int t = 0;
        while (n_rsp == start && t < 60) begin
            cycle();
            t++;
        end
        if (n_rsp == start) begin
            n_checks++;
            n_errors++;
            $display("FAIL wait_rsp: no response within 60 cycles");
        end
    endtask

    task automatic reset_pulse();
        i_rst = 1'b1;
        cycle();
        i_rst = 1'b0;
    endtask

    task automatic idle_outputs_check(input string tag);
        check({tag, "_busy"}, 64'(o_busy), 64'(0));
        check({tag, "_rsp_valid"}, 64'(o_rsp_valid), 64'(0));
        check({tag, "_res"}, 64'(o_rsp_res), 64'(0));
        check({tag, "_cry"}, 64'(o_rsp_cry), 64'(0));
        check({tag, "_id"}, 64'(o_rsp_id), 64'(0));
    endtask

    initial begin
        int t;
        i_rst       = 1'b1;
        i_req_valid = '0;
        i_req_num_a = '0;
        i_req_num_b = '0;
        i_req_cry   = '0;
        i_rsp_ready = '0;
        @(posedge i_clk);
        #1;
        mon_en = 1'b1;
        cycle();
        i_rst = 1'b0;
        idle_outputs_check("por");

        // Single request from requester 2.
        i_rsp_ready = '1;
        set_req(2, 8'h3C, 8'h05, 1'b1);
        wait_grant(2);
        wait_rsp();
        check("single_res", 64'(last_res), 64'(8'h42));
        check("single_cry", 64'(last_cry), 64'(0));
        check("single_id", 64'(last_id), 64'(2));

        // Overflow cases.
        set_req(0, 8'hFF, 8'h01, 1'b0);
        wait_grant(0);
        wait_rsp();
        check("ovf1_res", 64'(last_res), 64'(8'h00));
        check("ovf1_cry", 64'(last_cry), 64'(1));
        set_req(1, 8'hFF, 8'hFF, 1'b1);
        wait_grant(1);
        wait_rsp();
        check("ovf2_res", 64'(last_res), 64'(8'hFF));
        check("ovf2_cry", 64'(last_cry), 64'(1));

        // Round-robin with all requesters continuously valid.
        reset_pulse();
        grant_log.delete();
        grant_cyc.delete();
        hold_mode = 1'b1;
        for (int k = 0; k < N; k++) set_req(k, DW'($urandom), DW'($urandom), 1'($urandom));
        t = 0;
        while (grant_log.size() < 5 && t < 40) begin
            cycle();
            t++;
        end
        hold_mode   = 1'b0;
        i_req_valid = '0;
        check("rr_count", 64'(grant_log.size() >= 5), 64'(1));
        if (grant_log.size() >= 5) begin
            for (int i = 0; i < 5; i++) check("rr_order", 64'(grant_log[i]), 64'(i % N));
            for (int i = 1; i < 5; i++) check("rr_interval", 64'(grant_cyc[i] - grant_cyc[i-1]), 64'(3));
        end
        repeat (4) cycle();

        // Backpressure and wrong-owner ready.
        reset_pulse();
        i_rsp_ready = '0;
        set_req(1, 8'h10, 8'h20, 1'b0);
        wait_grant(1);
        set_req(0, 8'h01, 8'h02, 1'b0);
        set_req(3, 8'h0A, 8'h0B, 1'b1);
        cycle();
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("bp_busy", 64'(o_busy), 64'(1));
            check("bp_req_ready", 64'(o_req_ready), 64'(0));
            check("bp_res", 64'(o_rsp_res), 64'(8'h30));
        end
        i_rsp_ready = 4'b1000;
        cycle();
        i_rsp_ready = '0;
        check("wrong_owner_valid", 64'(o_rsp_valid), 64'(4'b0010));
        check("wrong_owner_id", 64'(o_rsp_id), 64'(1));
        i_rsp_ready = 4'b0010;
        cycle();
        check("bp_release_idle", 64'(o_busy), 64'(0));
        i_rsp_ready = '1;
        wait_grant(3);
        wait_grant(0);
        repeat (4) cycle();

        // Reset during CALC.
        set_req(2, 8'h55, 8'h66, 1'b1);
        wait_grant(2);
        i_rst = 1'b1;
        cycle();
        i_rst = 1'b0;
        idle_outputs_check("rst_calc");

        // Reset during RESP, then pointer restarts at 0.
        i_rsp_ready = '0;
        set_req(1, 8'h77, 8'h88, 1'b0);
        wait_grant(1);
        cycle();
        i_rst = 1'b1;
        cycle();
        i_rst = 1'b0;
        idle_outputs_check("rst_resp");
        set_req(3, 8'h12, 8'h34, 1'b0);
        set_req(0, 8'h56, 8'h78, 1'b1);
        i_rsp_ready = '1;
        wait_grant(0);
        check("rst_ptr_winner", 64'(grant_log[grant_log.size()-1]), 64'(0));
        wait_grant(3);
        repeat (4) cycle();

        // Random traffic with early withdrawal, random response ready and resets.
        for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < N; k++) begin
                if (!i_req_valid[k] && $urandom_range(0, 3) == 0)
                    set_req(k, DW'($urandom), DW'($urandom), 1'($urandom));
                else if (i_req_valid[k] && $urandom_range(0, 15) == 0)
                    i_req_valid[k] = 1'b0;
            end
            i_rsp_ready = N'($urandom);
            i_rst       = (c % 97 == 96);
            cycle();
        end
        i_rst       = 1'b0;
        i_req_valid = '0;
        i_rsp_ready = '1;
        repeat (6) cycle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
